log2_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one Log2 unit (start `h`, done `flag`, 8-bit unsigned in, 8-bit 3.5 fixed-point out) between N_REQ requesters.
- Accepts one request at a time, drives the unit's start/operand, waits for `flag`, and returns the result to the winning requester over a valid/ready response.
- Handles zero operands without using the unit, recovers a hung unit with a watchdog, and sits between the requesters and the single Log2 instance.

---
 rtl/log2_share_arb.sv | 166 ++++++++++++++++
 tb/tb_log2_share_arb.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log2_share_arb.sv
// log2_share_arb
// Round-robin arbiter that lets N_REQ requesters share one Log2 unit.
// It accepts one request at a time and starts the unit (lg_h, lg_in).
// It then waits for lg_flag and returns the result to the winning requester
// over a one-hot valid/ready response.
// A zero operand is answered directly with an error and never reaches the unit.
// A watchdog aborts a unit that never flags and resets it.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   req_valid  per-requester request valid
//   req_data   operands, requester i at [i*DATA_W +: DATA_W]
//   req_ready  one-hot accept to the round-robin winner (IDLE only)
//   rsp_valid  one-hot response valid to the owning requester
//   rsp_ready  per-requester response accept (only the owner's bit matters)
//   rsp_data   shared result bus (3.5 fixed point)
//   rsp_err    result invalid (zero operand or watchdog abort)
//   lg_h       start/hold to the Log2 unit
//   lg_in      operand to the Log2 unit, stable while lg_h=1
//   lg_flag    Log2 done
//   lg_out     Log2 result, valid with lg_flag
//   lg_reset   active-high reset to the Log2 unit
//   busy       high whenever the sequencer is not IDLE
module log2_share_arb #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_err,
    output logic                    lg_h,
    output logic [DATA_W-1:0]       lg_in,
    input  logic                    lg_flag,
    input  logic [DATA_W-1:0]       lg_out,
    output logic                    lg_reset,
    output logic                    busy
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [N_REQ-1:0]  ONE_HOT0 = N_REQ'(1);
    localparam logic [IDX_W-1:0]  PTR_INIT = IDX_W'(N_REQ - 1);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state_reg;
    logic [IDX_W-1:0]    ptr_reg;
    logic [IDX_W-1:0]    owner_reg;
    logic [WD_W-1:0]     wd_reg;
    logic [N_REQ-1:0]    rsp_valid_reg;
    logic [DATA_W-1:0]   rsp_data_reg;
    logic                rsp_err_reg;
    logic                lg_h_reg;
    logic [DATA_W-1:0]   lg_in_reg;
    logic                lg_reset_reg;

    logic                grant_found;
    logic [IDX_W-1:0]    grant_idx;
    logic [DATA_W-1:0]   grant_operand;

    // Round-robin search starting just after the last owner. The scan runs
    // from the far end of the search order back toward ptr+1, so that the
    // last hit written is the first candidate in round-robin order.
    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = (int'(ptr_reg) + k) % N_REQ;
            if (req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign grant_operand = req_data[grant_idx*DATA_W +: DATA_W];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = (state_reg == IDLE) && grant_found
                                   && (grant_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= PTR_INIT;
            owner_reg     <= '0;
            wd_reg        <= '0;
            rsp_valid_reg <= '0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
            lg_h_reg      <= 1'b0;
            lg_in_reg     <= '0;
            lg_reset_reg  <= 1'b1;
        end else begin
            lg_reset_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        owner_reg <= grant_idx;
                        ptr_reg   <= grant_idx;
                        if (grant_operand != '0) begin
                            lg_in_reg <= grant_operand;
                            lg_h_reg  <= 1'b1;
                            wd_reg    <= '0;
                            state_reg <= BUSY;
                        end else begin
                            // log2(0) is undefined: answer with an error
                            // straight away and leave the unit idle.
                            rsp_data_reg  <= '0;
                            rsp_err_reg   <= 1'b1;
                            rsp_valid_reg <= ONE_HOT0 << grant_idx;
                            state_reg     <= RESP;
                        end
                    end
                end
                BUSY: begin
                    wd_reg <= wd_reg + 1'b1;
                    // A flag on the same edge as the timeout takes priority.
                    if (lg_flag) begin
                        rsp_data_reg  <= lg_out;
                        rsp_err_reg   <= 1'b0;
                        lg_h_reg      <= 1'b0;
                        rsp_valid_reg <= ONE_HOT0 << owner_reg;
                        state_reg     <= RESP;
                    end else if (wd_reg == WD_LAST) begin
                        rsp_data_reg  <= '0;
                        rsp_err_reg   <= 1'b1;
                        lg_h_reg      <= 1'b0;
                        lg_reset_reg  <= 1'b1;
                        rsp_valid_reg <= ONE_HOT0 << owner_reg;
                        state_reg     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[owner_reg]) begin
                        rsp_valid_reg <= '0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;
    assign lg_h      = lg_h_reg;
    assign lg_in     = lg_in_reg;
    assign lg_reset  = lg_reset_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_log2_share_arb.sv
// Testbench for log2_share_arb: a Log2 stub with programmable latency,
// a round-robin/log2 reference model, and one task per scenario.
module tb_log2_share_arb;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TC = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*DW-1:0] req_data;
    logic [DW-1:0]   rsp_data, lg_in, lg_out;
    logic            rsp_err, lg_h, lg_flag, lg_reset, busy;

    int vectors     = 0;
    int miscompares = 0;
    int stub_delay  = 0;   // 0 = unit never flags
    int stub_cnt    = 0;
    int lg_h_count  = 0;
    int model_ptr   = N - 1;

    always #5 clk = ~clk;

    log2_share_arb #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(TC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .lg_h(lg_h), .lg_in(lg_in), .lg_flag(lg_flag), .lg_out(lg_out),
        .lg_reset(lg_reset), .busy(busy)
    );

    // Reference log2 in 3.5 fixed point (truncated); 0 maps to 0.
    function automatic logic [7:0] ref_log2(input int x);
        real r;
        if (x <= 0) return 8'h00;
        r = $ln(real'(x)) / $ln(2.0) * 32.0;
        return 8'($rtoi(r + 1.0e-6));
    endfunction

    // Round-robin rule: first valid requester after ptr, modulo N.
    function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Log2 stub: flags in the stub_delay-th cycle that lg_h is high.
    always @(posedge clk) begin
        stub_cnt   <= lg_h ? stub_cnt + 1 : 0;
        lg_h_count <= lg_h_count + (lg_h ? 1 : 0);
    end
    assign lg_flag = lg_h && (stub_delay != 0) && (stub_cnt == stub_delay - 1);
    assign lg_out  = lg_flag ? ref_log2(int'(lg_in)) : '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic wait_rsp(input int bound, output int cyc);
        cyc = 0;
        while (rsp_valid == '0 && cyc < bound) begin
            tick();
            cyc++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_valid = '0;
        tick();
        tick();
        reset = 1'b1;
        model_ptr = N - 1;
    endtask

    task automatic test_reset();
        rsp_ready = '1; req_data = '0; req_valid = '0; stub_delay = 0;
        reset = 1'b0;
        tick();
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        vectors++; if (rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
        vectors++; if (rsp_data !== 8'h00) begin miscompares++; $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); end
        vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err got=%0b exp=0", rsp_err); end
        vectors++; if (lg_h !== 1'b0) begin miscompares++; $display("FAIL reset_lg_h got=%0b exp=0", lg_h); end
        vectors++; if (lg_in !== 8'h00) begin miscompares++; $display("FAIL reset_lg_in got=%h exp=00", lg_in); end
        vectors++; if (lg_reset !== 1'b1) begin miscompares++; $display("FAIL reset_lg_reset got=%0b exp=1", lg_reset); end
        reset = 1'b1;
        tick();
        vectors++; if (lg_reset !== 1'b0) begin miscompares++; $display("FAIL reset_release_lg_reset got=%0b exp=0", lg_reset); end
        model_ptr = N - 1;
        $display("txn reset done");
    endtask

    task automatic test_single();
        int n;
        set_op(1, 8'd8); req_valid = 4'b0010; stub_delay = 6;
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL single_req_ready got=%b exp=0010", req_ready); end
        tick();
        req_valid = '0; model_ptr = 1;
        n = 0;
        while (lg_h === 1'b1 && n < 40) begin
            vectors++; if (lg_in !== 8'h08) begin miscompares++; $display("FAIL single_lg_in got=%h exp=08", lg_in); end
            n++;
            tick();
        end
        vectors++; if (n != 6) begin miscompares++; $display("FAIL single_busy_cycles got=%0d exp=6", n); end
        vectors++; if (rsp_valid !== 4'b0010) begin miscompares++; $display("FAIL single_rsp_valid got=%b exp=0010", rsp_valid); end
        vectors++; if (rsp_data !== 8'h60) begin miscompares++; $display("FAIL single_rsp_data got=%h exp=60", rsp_data); end
        vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL single_rsp_err got=%0b exp=0", rsp_err); end
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_idle_busy got=%0b exp=0", busy); end
        vectors++; if (rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL single_idle_rsp_valid got=%b exp=0000", rsp_valid); end
        vectors++; if (lg_h !== 1'b0) begin miscompares++; $display("FAIL single_idle_lg_h got=%0b exp=0", lg_h); end
        $display("txn single req=1 op=08 rsp=%h err=%0b busy_cycles=%0d", rsp_data, rsp_err, n);
    endtask

    task automatic test_zero();
        int h0, cyc;
        h0 = lg_h_count;
        set_op(2, 8'd0); req_valid = 4'b0100;
        #1;
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL zero_req_ready got=%b exp=0100", req_ready); end
        tick();
        req_valid = '0; model_ptr = 2;
        vectors++; if (rsp_valid !== 4'b0100) begin miscompares++; $display("FAIL zero_rsp_valid got=%b exp=0100", rsp_valid); end
        vectors++; if (rsp_data !== 8'h00) begin miscompares++; $display("FAIL zero_rsp_data got=%h exp=00", rsp_data); end
        vectors++; if (rsp_err !== 1'b1) begin miscompares++; $display("FAIL zero_rsp_err got=%0b exp=1", rsp_err); end
        vectors++; if (lg_h !== 1'b0) begin miscompares++; $display("FAIL zero_lg_h got=%0b exp=0", lg_h); end
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_idle_busy got=%0b exp=0", busy); end
        vectors++; if (lg_h_count != h0) begin miscompares++; $display("FAIL zero_lg_h_never got=%0d exp=%0d", lg_h_count, h0); end
        $display("txn zero req=2 rsp=00 err=1");
        set_op(3, 8'd1); req_valid = 4'b1000; stub_delay = 3;
        #1;
        vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL one_req_ready got=%b exp=1000", req_ready); end
        tick();
        req_valid = '0; model_ptr = 3;
        wait_rsp(40, cyc);
        vectors++; if (rsp_valid !== 4'b1000) begin miscompares++; $display("FAIL one_rsp_valid got=%b exp=1000", rsp_valid); end
        vectors++; if (cyc != 3) begin miscompares++; $display("FAIL one_latency got=%0d exp=3", cyc); end
        vectors++; if (rsp_data !== 8'h00) begin miscompares++; $display("FAIL one_rsp_data got=%h exp=00", rsp_data); end
        vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL one_rsp_err got=%0b exp=0", rsp_err); end
        tick();
        $display("txn one req=3 rsp=%h err=%0b", rsp_data, rsp_err);
    endtask

    task automatic test_rr_random();
        int w, cyc;
        logic [7:0] op, exp_d;
        logic [N-1:0] exp_oh;
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 8'($urandom_range(0, 255)));
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            w = rr_pick(model_ptr, req_valid);
            stub_delay = $urandom_range(1, 8);
            op = req_data[w*DW +: DW];
            exp_oh = N'(1) << w;
            #1;
            vectors++; if (req_ready !== exp_oh) begin miscompares++; $display("FAIL rr_req_ready k=%0d got=%b exp=%b", k, req_ready, exp_oh); end
            tick();
            model_ptr = w;
            set_op(w, 8'($urandom_range(0, 255)));
            wait_rsp(40, cyc);
            exp_d = (op == 0) ? 8'h00 : ref_log2(int'(op));
            vectors++; if (rsp_valid !== (N'(1) << (k % N))) begin miscompares++; $display("FAIL rr_order k=%0d got=%b exp_idx=%0d", k, rsp_valid, k % N); end
            vectors++; if (rsp_data !== exp_d) begin miscompares++; $display("FAIL rr_rsp_data k=%0d op=%h got=%h exp=%h", k, op, rsp_data, exp_d); end
            vectors++; if (rsp_err !== (op == 0)) begin miscompares++; $display("FAIL rr_rsp_err k=%0d got=%0b exp=%0b", k, rsp_err, op == 0); end
            $display("txn rr k=%0d req=%0d op=%h rsp=%h err=%0b", k, w, op, rsp_data, rsp_err);
            if (k == 4) req_valid = '0;
            tick();
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [7:0] op, exp_d;
        op = 8'($urandom_range(1, 255));
        exp_d = ref_log2(int'(op));
        set_op(1, op); req_valid = 4'b0010; stub_delay = 2; rsp_ready = 4'b1101;
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL bp_req_ready got=%b exp=0010", req_ready); end
        tick();
        model_ptr = 1; req_valid = '1;
        wait_rsp(40, cyc);
        for (int c = 0; c < 5; c++) begin
            vectors++; if (rsp_valid !== 4'b0010) begin miscompares++; $display("FAIL bp_rsp_valid c=%0d got=%b exp=0010", c, rsp_valid); end
            vectors++; if (rsp_data !== exp_d) begin miscompares++; $display("FAIL bp_rsp_data c=%0d got=%h exp=%h", c, rsp_data, exp_d); end
            vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL bp_rsp_err c=%0d got=%0b exp=0", c, rsp_err); end
            vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_req_ready_hold c=%0d got=%b exp=0000", c, req_ready); end
            vectors++; if (lg_h !== 1'b0) begin miscompares++; $display("FAIL bp_lg_h c=%0d got=%0b exp=0", c, lg_h); end
            tick();
        end
        vectors++; if (rsp_valid !== 4'b0010) begin miscompares++; $display("FAIL bp_rsp_valid_6th got=%b exp=0010", rsp_valid); end
        rsp_ready = '1; req_valid = '0;
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_release_busy got=%0b exp=0", busy); end
        vectors++; if (rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL bp_release_rsp_valid got=%b exp=0000", rsp_valid); end
        $display("txn backpressure req=1 op=%h rsp=%h", op, exp_d);
    endtask

    task automatic test_timeout();
        int n;
        logic [7:0] op, exp_d;
        // Unit never flags.
        op = 8'($urandom_range(1, 255));
        set_op(2, op); req_valid = 4'b0100; stub_delay = 0;
        #1;
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL to_req_ready got=%b exp=0100", req_ready); end
        tick();
        req_valid = '0; model_ptr = 2;
        n = 0;
        while (lg_h === 1'b1 && n < 40) begin n++; tick(); end
        vectors++; if (n != TC) begin miscompares++; $display("FAIL to_busy_cycles got=%0d exp=%0d", n, TC); end
        vectors++; if (rsp_valid !== 4'b0100) begin miscompares++; $display("FAIL to_rsp_valid got=%b exp=0100", rsp_valid); end
        vectors++; if (rsp_err !== 1'b1) begin miscompares++; $display("FAIL to_rsp_err got=%0b exp=1", rsp_err); end
        vectors++; if (rsp_data !== 8'h00) begin miscompares++; $display("FAIL to_rsp_data got=%h exp=00", rsp_data); end
        vectors++; if (lg_reset !== 1'b1) begin miscompares++; $display("FAIL to_lg_reset got=%0b exp=1", lg_reset); end
        tick();
        vectors++; if (lg_reset !== 1'b0) begin miscompares++; $display("FAIL to_lg_reset_pulse got=%0b exp=0", lg_reset); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL to_idle_busy got=%0b exp=0", busy); end
        $display("txn timeout req=2 op=%h busy_cycles=%0d", op, n);
        // Flag arrives on the last cycle before the watchdog would fire.
        op = 8'($urandom_range(1, 255));
        exp_d = ref_log2(int'(op));
        set_op(3, op); req_valid = 4'b1000; stub_delay = TC;
        #1;
        tick();
        req_valid = '0; model_ptr = 3;
        n = 0;
        while (lg_h === 1'b1 && n < 40) begin n++; tick(); end
        vectors++; if (n != TC) begin miscompares++; $display("FAIL late_busy_cycles got=%0d exp=%0d", n, TC); end
        vectors++; if (rsp_valid !== 4'b1000) begin miscompares++; $display("FAIL late_rsp_valid got=%b exp=1000", rsp_valid); end
        vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL late_rsp_err got=%0b exp=0", rsp_err); end
        vectors++; if (rsp_data !== exp_d) begin miscompares++; $display("FAIL late_rsp_data got=%h exp=%h", rsp_data, exp_d); end
        vectors++; if (lg_reset !== 1'b0) begin miscompares++; $display("FAIL late_lg_reset got=%0b exp=0", lg_reset); end
        tick();
        $display("txn late_flag req=3 op=%h rsp=%h", op, rsp_data);
    endtask

    task automatic test_reset_mid_busy();
        int cyc;
        logic [7:0] op;
        set_op(1, 8'($urandom_range(1, 255))); req_valid = 4'b0010; stub_delay = 0;
        #1;
        tick();
        req_valid = '0;
        tick();
        tick();
        vectors++; if (lg_h !== 1'b1) begin miscompares++; $display("FAIL mid_lg_h_before got=%0b exp=1", lg_h); end
        reset = 1'b0;
        tick();
        reset = 1'b1; model_ptr = N - 1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy got=%0b exp=0", busy); end
        vectors++; if (lg_h !== 1'b0) begin miscompares++; $display("FAIL mid_lg_h got=%0b exp=0", lg_h); end
        vectors++; if (rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL mid_rsp_valid got=%b exp=0000", rsp_valid); end
        vectors++; if (lg_reset !== 1'b1) begin miscompares++; $display("FAIL mid_lg_reset got=%0b exp=1", lg_reset); end
        op = 8'($urandom_range(1, 255));
        set_op(0, op); req_valid = '1; stub_delay = 2;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL mid_first_winner got=%b exp=0001", req_ready); end
        tick();
        req_valid = '0; model_ptr = 0;
        wait_rsp(40, cyc);
        vectors++; if (rsp_valid !== 4'b0001) begin miscompares++; $display("FAIL mid_rsp_owner got=%b exp=0001", rsp_valid); end
        vectors++; if (rsp_data !== ref_log2(int'(op))) begin miscompares++; $display("FAIL mid_rsp_data got=%h exp=%h", rsp_data, ref_log2(int'(op))); end
        tick();
        $display("txn reset_mid_busy then req=0 op=%h rsp=%h", op, rsp_data);
    endtask

    initial begin
        reset = 1'b0; req_valid = '0; req_data = '0; rsp_ready = '1;
        test_reset();
        test_single();
        test_zero();
        test_rr_random();
        test_backpressure();
        test_timeout();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end
endmodule
